// File: rtl/dmadd_pkg.sv
// Shared types and widths for the datapath-engine driver.
package dmadd_pkg;

    localparam int unsigned INSN_W         = 2;
    localparam int unsigned NIB_W          = 4;
    localparam int unsigned RES_W          = 12;
    localparam int unsigned CNT_W          = 5;
    localparam int unsigned IDX_W          = 4;
    localparam int unsigned WAIT_W         = 4;
    localparam int unsigned RUN_CYCLES_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_WAIT,
        ST_RESP
    } state_e;

endpackage

// File: rtl/dmadd_driver.sv
// Sequences a command through the engine: nibble loads, one run pulse, a fixed
// wait, then a held result on a valid/ready handshake.
module dmadd_driver
    import dmadd_pkg::*;
#(
    parameter int unsigned NSLOTS     = 16,
    parameter int unsigned RUN_CYCLES = RUN_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [INSN_W-1:0]      cmd_insn,
    input  logic [CNT_W-1:0]       cmd_count,
    input  logic                   op_valid,
    output logic                   op_ready,
    input  logic [NIB_W-1:0]       op_data,
    output logic                   dm_load,
    output logic                   dm_run,
    output logic [INSN_W-1:0]      dm_insn,
    output logic [IDX_W-1:0]       dm_index,
    output logic [NIB_W-1:0]       dm_data,
    input  logic [RES_W-NIB_W-1:0] dm_out,
    input  logic [NIB_W-1:0]       dm_out_top,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [RES_W-1:0]       res_data,
    output logic                   busy
);

    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(NSLOTS);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RUN_CYCLES);

    state_e               state_q, state_d;
    logic [INSN_W-1:0]    insn_q, insn_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [CNT_W-1:0]     acc_q, acc_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;

    logic                 cmd_ready_q, cmd_ready_d;
    logic                 op_ready_q, op_ready_d;
    logic                 busy_q, busy_d;
    logic                 dm_load_q, dm_load_d;
    logic                 dm_run_q, dm_run_d;
    logic [INSN_W-1:0]    dm_insn_q, dm_insn_d;
    logic [IDX_W-1:0]     dm_index_q, dm_index_d;
    logic [NIB_W-1:0]     dm_data_q, dm_data_d;
    logic                 res_valid_q, res_valid_d;
    logic [RES_W-1:0]     res_data_q, res_data_d;

    // Next-state, counters and next-cycle output values; handshake outputs
    // are decoded from the next state so they are registered with it.
    always_comb begin
        state_d    = state_q;
        insn_d     = insn_q;
        count_d    = count_q;
        acc_d      = acc_q;
        wait_d     = wait_q;
        dm_load_d  = 1'b0;
        dm_run_d   = 1'b0;
        dm_insn_d  = dm_insn_q;
        dm_index_d = dm_index_q;
        dm_data_d  = dm_data_q;
        res_data_d = res_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    insn_d  = cmd_insn;
                    count_d = (cmd_count > MAX_CNT) ? MAX_CNT : cmd_count;
                    acc_d   = '0;
                    state_d = (cmd_count == '0) ? ST_RUN : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (op_valid) begin
                    dm_load_d  = 1'b1;
                    dm_index_d = acc_q[IDX_W-1:0];
                    dm_data_d  = op_data;
                    acc_d      = acc_q + CNT_W'(1);
                    if (acc_q == count_q - CNT_W'(1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                dm_run_d  = 1'b1;
                dm_insn_d = insn_q;
                wait_d    = '0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    res_data_d = {dm_out_top, dm_out};
                    state_d    = ST_RESP;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_RESP: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        op_ready_d  = (state_d == ST_LOAD);
        busy_d      = (state_d != ST_IDLE);
        res_valid_d = (state_d == ST_RESP);
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            insn_q      <= '0;
            count_q     <= '0;
            acc_q       <= '0;
            wait_q      <= '0;
            cmd_ready_q <= 1'b1;
            op_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            dm_load_q   <= 1'b0;
            dm_run_q    <= 1'b0;
            dm_insn_q   <= '0;
            dm_index_q  <= '0;
            dm_data_q   <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            insn_q      <= insn_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            wait_q      <= wait_d;
            cmd_ready_q <= cmd_ready_d;
            op_ready_q  <= op_ready_d;
            busy_q      <= busy_d;
            dm_load_q   <= dm_load_d;
            dm_run_q    <= dm_run_d;
            dm_insn_q   <= dm_insn_d;
            dm_index_q  <= dm_index_d;
            dm_data_q   <= dm_data_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign op_ready  = op_ready_q;
    assign busy      = busy_q;
    assign dm_load   = dm_load_q;
    assign dm_run    = dm_run_q;
    assign dm_insn   = dm_insn_q;
    assign dm_index  = dm_index_q;
    assign dm_data   = dm_data_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

endmodule

// File: tb/tb_dmadd_driver.sv
// Scoreboard bench for dmadd_driver: the driver pushes expected engine events
// per command, a negedge monitor pops and compares them as the DUT emits them.
module tb_dmadd_driver;
    import dmadd_pkg::*;

    localparam int unsigned RC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_insn = '0;
    logic [4:0]  cmd_count = '0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [3:0]  op_data = '0;
    logic        dm_load;
    logic        dm_run;
    logic [1:0]  dm_insn;
    logic [3:0]  dm_index;
    logic [3:0]  dm_data;
    logic [7:0]  dm_out = '0;
    logic [3:0]  dm_out_top = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [11:0] res_data;
    logic        busy;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmadd_driver #(.NSLOTS(16), .RUN_CYCLES(RC)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_insn(cmd_insn), .cmd_count(cmd_count),
        .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
        .dm_load(dm_load), .dm_run(dm_run), .dm_insn(dm_insn),
        .dm_index(dm_index), .dm_data(dm_data),
        .dm_out(dm_out), .dm_out_top(dm_out_top),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy)
    );

    typedef struct { logic [3:0] idx; logic [3:0] data; int cyc; } load_t;
    typedef struct { logic [1:0] insn; int cyc; bit after_load; } run_t;
    typedef struct { logic [11:0] data; int cyc; } res_t;

    load_t load_q[$];
    run_t  run_q[$];
    res_t  res_q[$];
    logic [3:0] nib [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_op_ready"},  32'(op_ready),  32'd0);
        chk({tag, "_dm_load"},   32'(dm_load),   32'd0);
        chk({tag, "_dm_run"},    32'(dm_run),    32'd0);
        chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_dm_index"},  32'(dm_index),  32'd0);
        chk({tag, "_dm_data"},   32'(dm_data),   32'd0);
        chk({tag, "_dm_insn"},   32'(dm_insn),   32'd0);
        chk({tag, "_res_data"},  32'(res_data),  32'd0);
    endtask

    // Monitor: compare every engine pulse and result against the scoreboard.
    logic        was_valid = 1'b0;
    logic        hold_prev = 1'b0;
    logic [11:0] data_prev = '0;
    bit          exp_cready = 1'b0;
    int          last_load_cyc = -10;

    always @(negedge clk) begin : mon
        load_t le;
        run_t  re;
        res_t  rs;
        if (rst) begin
            was_valid  = 1'b0;
            hold_prev  = 1'b0;
            exp_cready = 1'b0;
        end else begin
            if (dm_load || dm_run)
                chk("load_run_exclusive", 32'(dm_load & dm_run), 32'd0);
            if (exp_cready) begin
                chk("cmd_ready_after_hs", 32'(cmd_ready), 32'd1);
                exp_cready = 1'b0;
            end
            if (dm_load) begin
                if (load_q.size() == 0) note_fail("unexpected_load");
                else begin
                    le = load_q.pop_front();
                    chk("load_index", 32'(dm_index), 32'(le.idx));
                    chk("load_data",  32'(dm_data),  32'(le.data));
                    if (le.cyc >= 0) chk("load_cycle", 32'(cyc), 32'(le.cyc));
                end
                last_load_cyc = cyc;
            end
            if (dm_run) begin
                if (run_q.size() == 0) note_fail("unexpected_run");
                else begin
                    re = run_q.pop_front();
                    chk("run_insn", 32'(dm_insn), 32'(re.insn));
                    if (re.cyc >= 0) chk("run_cycle", 32'(cyc), 32'(re.cyc));
                    if (re.after_load)
                        chk("run_after_last_load", 32'(cyc), 32'(last_load_cyc + 1));
                end
            end
            if (res_valid && !was_valid) begin
                if (res_q.size() == 0) note_fail("unexpected_res");
                else if (res_q[0].cyc >= 0)
                    chk("res_valid_cycle", 32'(cyc), 32'(res_q[0].cyc));
            end
            if (hold_prev) begin
                chk("res_valid_held",  32'(res_valid), 32'd1);
                chk("res_data_stable", 32'(res_data),  32'(data_prev));
            end
            if (res_valid && !res_ready) begin
                chk("cmd_ready_in_resp", 32'(cmd_ready), 32'd0);
                chk("busy_in_resp",      32'(busy),      32'd1);
            end
            if (res_valid && res_ready) begin
                if (res_q.size() != 0) begin
                    rs = res_q.pop_front();
                    chk("res_data", 32'(res_data), 32'(rs.data));
                end
                exp_cready = 1'b1;
            end
            was_valid = res_valid;
            hold_prev = res_valid && !res_ready;
            data_prev = res_data;
        end
    end

    // Issue one command; expectations come from the command itself: the first
    // min(count,16) nibbles at indices 0.., one run, then the engine value.
    task automatic run_txn(input logic [1:0] insn, input logic [4:0] count,
                           input int mode, input int hold,
                           input logic [11:0] engine, input bit abort);
        int n, t0, acc, step, guard;
        logic [4:0] pat;
        bit v, accepted;
        load_t le;
        run_t  re;
        res_t  rs;
        n = (count > 5'd16) ? 16 : int'(count);
        pat = 5'b11001;
        guard = 0;
        while (!cmd_ready && guard < 100) begin tick(); guard++; end
        if (!cmd_ready) begin note_fail("cmd_ready_timeout"); return; end
        cmd_valid = 1'b1;
        cmd_insn = insn;
        cmd_count = count;
        {dm_out_top, dm_out} = engine;
        op_valid = 1'b0;
        res_ready = 1'b0;
        t0 = cyc;
        for (int k = 0; k < n; k++) begin
            le.idx = 4'(k);
            le.data = nib[k];
            le.cyc = (mode == 0) ? t0 + 2 + k : -1;
            load_q.push_back(le);
        end
        re.insn = insn;
        re.cyc = (mode == 0) ? t0 + n + 2 : -1;
        re.after_load = (n > 0);
        run_q.push_back(re);
        if (!abort) begin
            rs.data = engine;
            rs.cyc = (mode == 0) ? t0 + n + 3 + int'(RC) : -1;
            res_q.push_back(rs);
        end
        tick();
        cmd_valid = 1'b0;
        acc = 0;
        step = 0;
        while (acc < n && step < 200) begin
            case (mode)
                0: v = 1'b1;
                1: v = (step < 5) ? pat[step] : 1'b1;
                default: v = ($urandom_range(0, 9) < 7);
            endcase
            op_valid = v;
            op_data = v ? nib[acc] : 4'($urandom);
            cmd_valid = 1'($urandom);
            cmd_insn = 2'($urandom);
            cmd_count = 5'($urandom);
            res_ready = 1'($urandom);
            accepted = v && op_ready;
            tick();
            if (accepted) acc++;
            step++;
        end
        op_valid = 1'b0;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        if (acc < n) begin note_fail("op_accept_timeout"); return; end
        if (abort) begin
            guard = 0;
            while (!dm_run && guard < 50) begin tick(); guard++; end
            tick();
            rst = 1'b1;
            res_q.delete();
            tick();
            rst = 1'b0;
            check_idle_outputs("abort");
            repeat (12) tick();
            return;
        end
        guard = 0;
        while (!res_valid && guard < 100) begin
            op_valid = 1'($urandom);
            op_data = 4'($urandom);
            tick();
            guard++;
        end
        op_valid = 1'b0;
        if (!res_valid) begin note_fail("res_valid_timeout"); return; end
        repeat (hold) begin
            {dm_out_top, dm_out} = 12'($urandom);
            tick();
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic rand_nibs();
        for (int k = 0; k < 16; k++) nib[k] = 4'($urandom);
    endtask

    initial begin
        for (int k = 0; k < 16; k++) nib[k] = '0;
        repeat (3) tick();
        rst = 1'b0;
        check_idle_outputs("reset");

        nib[0] = 4'hA; nib[1] = 4'h5; nib[2] = 4'hF;
        run_txn(2'b01, 5'd3, 0, 0, 12'h3C7, 1'b0);

        run_txn(2'b10, 5'd0, 0, 0, 12'($urandom), 1'b0);

        for (int k = 0; k < 16; k++) nib[k] = 4'(k);
        run_txn(2'b11, 5'd20, 0, 0, 12'($urandom), 1'b0);

        rand_nibs();
        run_txn(2'b00, 5'd3, 1, 5, 12'($urandom), 1'b0);
        rand_nibs();
        run_txn(2'b01, 5'd2, 0, 0, 12'($urandom), 1'b0);

        rand_nibs();
        run_txn(2'b10, 5'd16, 2, 2, 12'($urandom), 1'b0);

        rand_nibs();
        run_txn(2'b01, 5'd2, 0, 0, 12'($urandom), 1'b1);
        rand_nibs();
        run_txn(2'b11, 5'd4, 0, 0, 12'($urandom), 1'b0);

        for (int t = 0; t < 30; t++) begin
            rand_nibs();
            run_txn(2'($urandom), 5'($urandom_range(0, 20)), $urandom_range(0, 2),
                    $urandom_range(0, 3), 12'($urandom), 1'b0);
        end

        repeat (6) tick();
        chk("load_q_drained", 32'(load_q.size()), 32'd0);
        chk("run_q_drained",  32'(run_q.size()),  32'd0);
        chk("res_q_drained",  32'(res_q.size()),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmadd_driver.md
DMADD_DRIVER -- requirements
Module: dmadd_driver

Interface
REQ-001 SHALL have parameter NSLOTS, default 16, meaning the number of nibble slots addressable via dm_index.
REQ-002 SHALL have parameter RUN_CYCLES, default 4, meaning the number of cycles from the dm_run pulse to the result capture; legal range 1..15.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port: clk  in  1  sole clock, rising edge.
REQ-005 Port: rst  in  1  synchronous active-high reset.
REQ-006 Port: cmd_valid in 1 / cmd_ready out 1  command handshake.
REQ-007 Port: cmd_insn  in  2  instruction code forwarded to dm_insn.
REQ-008 Port: cmd_count  in  5  number of nibbles to load (0..16).
REQ-009 Port: op_valid in 1 / op_ready out 1 / op_data in 4  operand nibble stream.
REQ-010 Port: dm_load out 1, dm_run out 1, dm_insn out 2, dm_index out 4, dm_data out 4  datapath-engine drive side, all registered.
REQ-011 Port: dm_out in 8, dm_out_top in 4  engine result, low byte and top nibble.
REQ-012 Port: res_valid out 1 / res_ready in 1 / res_data out 12  result handshake.
REQ-013 Port: busy  out  1  high in every state except IDLE.

Function
REQ-014 SHALL implement an FSM with states IDLE, LOAD, RUN, WAIT and RESP.
REQ-015 IDLE: cmd_ready=1; on cmd_valid, SHALL latch insn and count (saturated to 16 if >16) and clear the index.
- count=0: SHALL go to RUN.
- otherwise: SHALL go to LOAD.
REQ-016 LOAD: op_ready=1; each accepted op nibble SHALL produce, in the following cycle, a one-cycle dm_load=1 with dm_index equal to the current index and dm_data equal to op_data.
- index increments by 1 on each accept.
- acceptance of nibble count-1 SHALL move the FSM to RUN.
REQ-017 op_valid low in LOAD SHALL stall without a dm_load pulse; op_valid outside LOAD SHALL be ignored, with op_ready=0.
REQ-018 RUN SHALL last one cycle and produce dm_run=1 and dm_insn=insn in the cycle after RUN; dm_run and dm_load SHALL never be high together.
REQ-019 WAIT SHALL count RUN_CYCLES cycles from the dm_run cycle, then capture res_data={dm_out_top, dm_out} and go to RESP with res_valid=1.
REQ-020 RESP SHALL hold res_valid and res_data stable until res_ready; on handshake the FSM SHALL go to IDLE, so cmd_ready is high the next cycle.
REQ-021 Latency with no stalls, count=N≥1, cmd accepted in cycle 0:
- dm_load high in cycles 2..N+1;
- dm_run high in cycle N+2;
- res_valid first high in cycle N+3+RUN_CYCLES.
REQ-022 With count=0, dm_run SHALL be high in cycle 2 and no dm_load pulse SHALL occur.
REQ-023 dm_index SHALL wrap modulo 16; with count=16, the last load SHALL use index 15.
REQ-024 cmd_valid while busy SHALL be ignored (cmd_ready=0); res_ready while not RESP SHALL be ignored.
REQ-025 dm_index, dm_data and dm_insn SHALL hold their last values between pulses.

Reset
REQ-026 On rst=1 at a clock edge, SHALL enter IDLE and zero all outputs, so cmd_ready=1 in the first cycle after reset.
REQ-027 Reset mid-LOAD/RUN/WAIT/RESP SHALL abort the transaction with no further dm_load/dm_run pulses and discard any pending result; reset SHALL take priority over all handshakes in the same cycle.

Structure
REQ-028 Shared package dmadd_pkg SHALL hold:
- the FSM state enum;
- widths INSN_W=2, NIB_W=4, RES_W=12, CNT_W=5;
- default RUN_CYCLES.
REQ-029 SHALL be a single module with no sub-module; the latency counter and index counter are inline registers.

Verification
REQ-030 Command insn=2'b01, count=3, nibbles 0xA, 0x5, 0xF with op_valid held high, engine returns 0x3C7 -> dm_load in cycles 2..4 at index 0,1,2 with data A,5,F; dm_run with insn=01 in cycle 5; res_valid in cycle 10 with res_data=0x3C7.
REQ-031 Command count=0 -> no dm_load pulse; dm_run in cycle 2; res_valid in cycle 7.
REQ-032 Command count=20 with nibbles 0..15 -> exactly 16 loads, indices 0..15, then one dm_run.
REQ-033 op_valid toggled 1,0,0,1,1 with count=3 -> loads only after accepted nibbles, no gaps misattributed, dm_run one cycle after the last load.
REQ-034 res_ready held low 5 cycles -> res_data stable, cmd_ready=0; then res_ready=1 -> cmd_ready=1 next cycle; a second command is accepted back-to-back.
REQ-035 rst asserted in the WAIT state -> next cycle IDLE with all outputs 0, no res_valid; a subsequent command completes normally.
